// File: rtl/iccm_loader.sv
// Boot-time ICCM loader: takes a length-prefixed little-endian byte stream,
// writes it into the ICCM one word at a time and releases the core when done.
module iccm_loader #(
  parameter int DEPTH_WORDS = 4096,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        iccm_wr_en,
  output logic [31:0] iccm_wr_addr,
  output logic [31:0] iccm_wr_data,
  output logic        core_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, LEN, DATA, DONE} state_e;

  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH_WORDS);

  state_e           state_q, state_d;
  logic [1:0]       lane_q, lane_d;
  logic [31:0]      data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] len_q, len_d;
  logic             wr_en_d;
  logic [31:0]      wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic             done_q, done_d, err_q, err_d;
  logic             busy_q, busy_d, hold_q, hold_d;
  logic             wr_en_q;
  logic             accept;
  logic [31:0]      word;

  // Ready depends on state only, so the source can never combinationally loop.
  assign byte_ready = (state_q == LEN) || (state_q == DATA);
  assign accept     = byte_valid & byte_ready;
  assign word       = {byte_data, data_q[23:0]};
  assign cnt_inc    = cnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = done_q;
    err_d     = err_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LEN;
          lane_d  = 2'd0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      LEN, DATA: begin
        if (accept) begin
          data_d[{lane_q, 3'b000} +: 8] = byte_data;
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            if (state_q == LEN) begin
              // Header: reject anything that does not fit, including high bits beyond CNT_W.
              if ((word[31:CNT_W] != '0) || ({1'b0, word[CNT_W-1:0]} > DEPTH_C)) begin
                state_d = DONE;
                err_d   = 1'b1;
              end else if (word[CNT_W-1:0] == '0) begin
                state_d = DONE;
                done_d  = 1'b1;
              end else begin
                state_d = DATA;
                len_d   = word[CNT_W-1:0];
                cnt_d   = '0;
              end
            end else begin
              wr_en_d   = 1'b1;
              wr_addr_d = {{(32-CNT_W){1'b0}}, cnt_q};
              wr_data_d = word;
              cnt_d     = cnt_inc;
              if (cnt_inc == len_q) begin
                state_d = DONE;
                done_d  = 1'b1;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == LEN) || (state_d == DATA);
    hold_d = !((state_d == DONE) && !err_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      lane_q    <= 2'd0;
      data_q    <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      hold_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      hold_q    <= hold_d;
    end
  end

  assign iccm_wr_en   = wr_en_q;
  assign iccm_wr_addr = wr_addr_q;
  assign iccm_wr_data = wr_data_q;
  assign core_hold    = hold_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule
